// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit FIFO block.
package uart_pkg;

    localparam int DEFAULT_DEPTH       = 16;
    localparam int DEFAULT_ACK_TIMEOUT = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with occupancy count, full/empty flags and a sticky overflow flag.
// Full is judged on the registered count, so a push into a full FIFO is dropped even if a pop happens that cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end else if (push && full) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte queue feeding a UART transmitter through a send_en / send_busy handshake.
// Handshake: send_en pulses one cycle with send_data valid; the transmitter acknowledges by raising send_busy and frees by dropping it.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic                   send_en,
    output logic [7:0]             send_data,
    input  logic                   send_busy,
    output logic                   ack_err,
    output state_t                 state
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t        state_q;
    state_t        state_d;
    logic          pop;
    logic [7:0]    pop_data;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_next;
    logic          tmo_clr;
    logic          tmo_inc;

    assign state    = state_q;
    assign tmo_next = tmo_cnt + TW'(1);

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        send_en = 1'b0;
        ack_err = 1'b0;
        tmo_clr = 1'b0;
        tmo_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !send_busy) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                send_en = 1'b1;
                tmo_clr = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Timeout fires on the cycle the count would reach ACK_TIMEOUT,
                // i.e. ACK_TIMEOUT cycles after the send_en pulse.
                if (send_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_next == TW'(ACK_TIMEOUT)) begin
                    ack_err = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!send_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (tmo_clr) begin
            tmo_cnt <= '0;
        end else if (tmo_inc) begin
            tmo_cnt <= tmo_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_data <= 8'h00;
        end else if (pop) begin
            send_data <= pop_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks of uart_tx_fifo against a byte-queue scoreboard and a transmitter model.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 8;
    localparam int CW          = $clog2(DEPTH) + 1;
    localparam int TX_AUTO     = 0;
    localparam int TX_FORCE    = 1;
    localparam int TX_DEAD     = 2;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;
    logic          ovf_clr;
    logic          send_en;
    logic [7:0]    send_data;
    logic          send_busy;
    logic          ack_err;
    state_t        state;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            sends    = 0;
    int            tx_mode  = TX_DEAD;
    logic [7:0]    exp_q[$];
    logic [7:0]    got_q[$];

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .send_en   (send_en),
        .send_data (send_data),
        .send_busy (send_busy),
        .ack_err   (ack_err),
        .state     (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        exp_q.delete();
        got_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // push one byte; queued in the scoreboard only when the caller expects acceptance
    task automatic push(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            tick(1);
            done = (exp_q.size() == 0) && (state == IDLE) && empty && !send_busy;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // transmitter model: busy rises one cycle after send_en and stays up for 10 cycles
    initial begin
        int  hold = 0;
        bit  pend = 1'b0;
        send_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_mode == TX_FORCE) begin
                send_busy = 1'b1;
                hold = 0;
                pend = 1'b0;
            end else if (tx_mode == TX_DEAD) begin
                send_busy = 1'b0;
                hold = 0;
                pend = 1'b0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) send_busy = 1'b0;
                end else if (pend) begin
                    send_busy = 1'b1;
                    hold = 10;
                    pend = 1'b0;
                end else begin
                    send_busy = 1'b0;
                end
                if (send_en) pend = 1'b1;
            end
        end
    end

    // scoreboard and handshake monitor
    initial begin
        bit outstanding = 1'b0;
        bit busy_rose   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outstanding = 1'b0;
                busy_rose   = 1'b0;
            end else begin
                if (ack_err) outstanding = 1'b0;
                if (outstanding && send_busy) busy_rose = 1'b1;
                if (outstanding && busy_rose && !send_busy) begin
                    outstanding = 1'b0;
                    busy_rose   = 1'b0;
                end
                if (send_en) begin
                    check("send_en_without_handshake", 32'(outstanding), 32'd0);
                    outstanding = 1'b1;
                    busy_rose   = 1'b0;
                    sends++;
                    got_q.push_back(send_data);
                    if (exp_q.size() == 0) begin
                        check("unexpected_send_en", 32'(send_data), 32'hFFFF_FFFF);
                    end else begin
                        check("send_data_order", 32'(send_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int         snap;
        int         cyc;
        bit         seen;
        bit         saw_full;
        logic [7:0] b;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        #1;

        // reset values
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_send_en", 32'(send_en), 32'd0);
        check("rst_send_data", 32'(send_data), 32'h00);
        check("rst_ack_err", 32'(ack_err), 32'd0);

        // two bytes through an auto-acknowledging transmitter, with start latency
        tx_mode = TX_AUTO;
        do_reset();
        snap = sends;
        push(8'h48, 1'b1);
        wr_en   = 1'b1;
        wr_data = 8'h69;
        exp_q.push_back(8'h69);
        check("latency_c1", 32'(send_en), 32'd0);
        tick(1);
        wr_en = 1'b0;
        check("latency_c2", 32'(send_en), 32'd0);
        tick(1);
        check("latency_c3_send_en", 32'(send_en), 32'd1);
        check("latency_c3_data", 32'(send_data), 32'h48);
        wait_idle("two_byte_drain", 200);
        check("two_byte_sends", 32'(sends - snap), 32'd2);
        check("two_byte_first", 32'(got_q.size() > 0 ? got_q[0] : 8'hxx), 32'h48);
        check("two_byte_second", 32'(got_q.size() > 1 ? got_q[1] : 8'hxx), 32'h69);
        check("two_byte_empty", 32'(empty), 32'd1);

        // fill to full with the transmitter held busy, then overflow
        tx_mode = TX_FORCE;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push(8'(8'h10 + i), 1'b1);
            if (i == DEPTH - 2) check("not_full_at_15", 32'(full), 32'd0);
        end
        check("full_after_16", 32'(full), 32'd1);
        check("count_at_16", 32'(count), 32'(DEPTH));
        check("ovf_before_drop", 32'(ovf), 32'd0);
        push(8'hEE, 1'b0);
        check("ovf_after_drop", 32'(ovf), 32'd1);
        check("count_after_drop", 32'(count), 32'(DEPTH));
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // push while full on the same cycle the FSM pops
        tx_mode = TX_AUTO;
        wr_en   = 1'b1;
        wr_data = 8'h42;
        tick(1);
        wr_en = 1'b0;
        check("push_pop_full_count", 32'(count), 32'(DEPTH - 1));
        check("push_pop_full_ovf", 32'(ovf), 32'd1);
        check("push_pop_full_state", 32'(state), 32'(LOAD));
        wait_idle("full_drain", 1000);

        // transmitter never acknowledges
        tx_mode = TX_DEAD;
        do_reset();
        push(8'h5A, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (send_en) seen = 1'b1;
            else tick(1);
        end
        check("timeout_send_en_seen", 32'(seen), 32'd1);
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 4 * ACK_TIMEOUT && !seen; i++) begin
            tick(1);
            cyc++;
            if (ack_err) seen = 1'b1;
        end
        check("ack_err_delay", 32'(cyc), 32'(ACK_TIMEOUT));
        tick(1);
        check("ack_err_one_cycle", 32'(ack_err), 32'd0);
        check("timeout_idle", 32'(state), 32'(IDLE));
        check("timeout_empty", 32'(empty), 32'd1);

        // random bytes paced below the drain rate, across pointer wrap-around
        tx_mode = TX_AUTO;
        do_reset();
        snap     = sends;
        saw_full = 1'b0;
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            b = 8'($urandom_range(0, 255));
            push(b, 1'b1);
            for (int g = $urandom_range(14, 22); g > 0; g--) begin
                tick(1);
                if (full) saw_full = 1'b1;
            end
        end
        wait_idle("random_drain", 1000);
        check("random_sends", 32'(sends - snap), 32'(2 * DEPTH + 3));
        check("random_never_full", 32'(saw_full), 32'd0);

        // reset in WAIT_DONE with bytes queued
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'hA0 + i), 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (state == WAIT_DONE) seen = 1'b1;
            else tick(1);
        end
        check("reached_wait_done", 32'(seen), 32'd1);
        check("queued_before_reset", 32'(count), 32'd5);
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'(IDLE));
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_full", 32'(full), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_send_en", 32'(send_en), 32'd0);
        check("midrst_send_data", 32'(send_data), 32'h00);
        check("midrst_ack_err", 32'(ack_err), 32'd0);
        exp_q.delete();
        tx_mode = TX_DEAD;
        tick(2);
        rst_n = 1'b1;
        snap = sends;
        tick(30);
        check("no_send_after_reset", 32'(sends - snap), 32'd0);
        tx_mode = TX_AUTO;
        push(8'hC3, 1'b1);
        wait_idle("post_reset_drain", 200);
        check("post_reset_one_send", 32'(sends - snap), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 8, clock cycles allowed for send_busy to rise after send_en.
REQ-003 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr_en, input, 1, a one-cycle byte-push strobe.
REQ-006 SHALL have port wr_data, input, 8, the byte to push.
REQ-007 SHALL have port full, output, 1, set when count == DEPTH.
REQ-008 SHALL have port empty, output, 1, set when count == 0.
REQ-009 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-010 SHALL have port ovf, output, 1, sticky flag set when a push is dropped.
REQ-011 SHALL have port ovf_clr, input, 1, which clears ovf.
REQ-012 SHALL have port send_en, output, 1, a one-cycle start strobe to the transmitter.
REQ-013 SHALL have port send_data, output, 8, the byte presented with send_en.
REQ-014 SHALL have port send_busy, input, 1, the transmitter busy indication.
REQ-015 SHALL have port ack_err, output, 1, a one-cycle pulse raised on ACK_TIMEOUT expiry.

Function
REQ-016 SHALL store pushed bytes FIFO-ordered in a DEPTH x 8 memory; write and read pointers wrap modulo DEPTH.
REQ-017 SHALL accept a push when wr_en=1 and full=0: store wr_data at the write pointer, then increment the write pointer.
REQ-018 SHALL drop a push when wr_en=1 and full=1: memory and pointers unchanged, ovf<=1.
REQ-019 SHALL evaluate full before a same-cycle pop; a push and pop in the same cycle while full drops the push.
REQ-020 SHALL leave count unchanged when an accepted push and a pop occur in the same cycle.
REQ-021 SHALL treat ovf_clr as winning over a simultaneous overflow, so ovf<=0.
REQ-022 SHALL implement FSM states IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-023 IDLE: when empty=0 and send_busy=0, pop one byte into the send_data register and go to LOAD; otherwise hold.
REQ-024 LOAD: send_data stable; go to ISSUE next cycle.
REQ-025 ISSUE: send_en=1 for exactly this cycle; clear the timeout counter; go to WAIT_ACK.
REQ-026 WAIT_ACK: send_busy=1 -> WAIT_DONE.
REQ-027 WAIT_ACK: if the timeout counter reaches ACK_TIMEOUT, pulse ack_err for one cycle, discard the byte and go to IDLE.
REQ-028 WAIT_ACK: otherwise increment the timeout counter.
REQ-029 WAIT_DONE: send_busy=0 -> IDLE; otherwise hold.
REQ-030 SHALL give a minimum of 3 cycles from a push into an empty FIFO to send_en, with send_busy=0 throughout.
REQ-031 SHALL hold send_data constant from LOAD until the FSM leaves WAIT_DONE or WAIT_ACK.
REQ-032 SHALL keep send_en low in every state other than ISSUE.
REQ-033 SHALL never assert send_en twice without send_busy having risen and fallen in between, except after an ack_err.

Reset
REQ-034 SHALL, while rst_n=0, asynchronously force the state to IDLE, both pointers and count to 0, empty=1, full=0, ovf=0, send_en=0, send_data=8'h00, ack_err=0 and the timeout counter to 0.
REQ-035 SHALL discard FIFO contents and any byte in flight on reset assertion mid-operation; memory contents need not be cleared.
REQ-036 SHALL behave identically after reset release whatever its state was before reset.

Structure
REQ-037 SHALL take the FSM state enum and the default DEPTH and ACK_TIMEOUT constants from the shared package uart_pkg.
REQ-038 SHALL implement the storage, pointers, count, full, empty and ovf in one sub-module, sync_fifo, with the FSM in uart_tx_fifo.
REQ-039 SHALL drive send_en, send_busy and send_data so they connect directly to uart_tx's send_en, send_busy and send_data ports.

Verification
REQ-040 SHALL pass: push 8'h48, 8'h69 into an empty FIFO; the transmitter model raises busy 1 cycle after send_en and holds it 10 cycles -> send_data=48 then 69 in order, exactly two send_en pulses, empty=1 at the end.
REQ-041 SHALL pass: hold send_busy=1 and push 17 bytes with DEPTH=16 -> full=1 after the 16th push, 17th push dropped, ovf=1, count=16; ovf_clr -> ovf=0.
REQ-042 SHALL pass: with the FIFO full, assert wr_en on the same cycle the FSM pops -> push dropped, count=15, ovf=1.
REQ-043 SHALL pass: push a byte with send_busy never rising -> ack_err pulses once ACK_TIMEOUT cycles after send_en, FSM returns to IDLE, empty=1.
REQ-044 SHALL pass: push 2*DEPTH+3 bytes paced to never fill the FIFO -> all bytes emerge in order across pointer wrap-around.
REQ-045 SHALL pass: assert rst_n=0 during WAIT_DONE with 5 bytes queued -> all outputs at reset values immediately, count=0, no send_en after release until a new push.
